// File: rtl/nand_seq_pkg.sv
// Shared state encoding and register map for the NAND command sequencer.
package nand_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_POLL_RD,
    S_POLL_CHK,
    S_XFER_WR,
    S_XFER_RD,
    S_RD_CAP,
    S_DONE
  } state_t;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CMD    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int STATUS_BUSY_BIT = 0;

endpackage

// File: rtl/nand_cmd_sequencer.sv
// Runs one NAND operation (command write, busy polling, optional data burst)
// onto the controller's register port; every bus output is registered.
module nand_cmd_sequencer
  import nand_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 12,
  parameter int POLL_MAX = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [7:0]        i_req_cmd,
  input  logic              i_req_dir,
  input  logic [CNT_W-1:0]  i_req_nwords,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_done,
  output logic              o_err,
  output logic [1:0]        o_avm_addr,
  output logic              o_avm_wr,
  output logic              o_avm_rd,
  output logic [DATA_W-1:0] o_avm_wrdata,
  input  logic [DATA_W-1:0] i_avm_rddata
);

  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0] POLL_LIMIT = PW'(POLL_MAX);

  state_t            r_state;
  logic              r_dir;
  logic [CNT_W-1:0]  r_remain;
  logic [PW-1:0]     r_poll;
  logic              r_req_ready;
  logic              r_wr_ready;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_done;
  logic              r_err;
  logic [1:0]        r_avm_addr;
  logic              r_avm_wr;
  logic              r_avm_rd;
  logic [DATA_W-1:0] r_avm_wrdata;

  logic [PW-1:0]     w_poll_next;
  logic              w_busy;

  always_comb begin
    w_poll_next = (r_poll == POLL_LIMIT) ? r_poll : r_poll + PW'(1);
    w_busy      = i_avm_rddata[STATUS_BUSY_BIT];
  end

  // Outputs are loaded on the edge that enters the state they belong to.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_dir        <= 1'b0;
      r_remain     <= '0;
      r_poll       <= '0;
      r_req_ready  <= 1'b0;
      r_wr_ready   <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_rd_data    <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_avm_addr   <= REG_DATA;
      r_avm_wr     <= 1'b0;
      r_avm_rd     <= 1'b0;
      r_avm_wrdata <= '0;
    end else begin
      r_avm_wr   <= 1'b0;
      r_avm_rd   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (i_req_valid && r_req_ready) begin
            r_dir        <= i_req_dir;
            r_remain     <= i_req_nwords;
            r_req_ready  <= 1'b0;
            r_avm_addr   <= REG_CMD;
            r_avm_wr     <= 1'b1;
            r_avm_wrdata <= DATA_W'(i_req_cmd);
            r_state      <= S_CMD;
          end
        end
        S_CMD: begin
          r_poll     <= '0;
          r_avm_addr <= REG_STATUS;
          r_avm_rd   <= 1'b1;
          r_state    <= S_POLL_RD;
        end
        S_POLL_RD: begin
          r_state <= S_POLL_CHK;
        end
        S_POLL_CHK: begin
          if (!w_busy) begin
            if (r_remain == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else if (r_dir) begin
              r_avm_addr <= REG_DATA;
              r_wr_ready <= 1'b1;
              r_state    <= S_XFER_WR;
            end else begin
              r_avm_addr <= REG_DATA;
              r_avm_rd   <= 1'b1;
              r_state    <= S_XFER_RD;
            end
          end else begin
            r_poll <= w_poll_next;
            if (w_poll_next == POLL_LIMIT) begin
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_avm_rd <= 1'b1;
              r_state  <= S_POLL_RD;
            end
          end
        end
        S_XFER_WR: begin
          if (i_wr_valid) begin
            r_avm_wr     <= 1'b1;
            r_avm_wrdata <= i_wr_data;
            r_remain     <= r_remain - CNT_W'(1);
            if (r_remain == CNT_W'(1)) begin
              r_wr_ready <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end
          end
        end
        S_XFER_RD: begin
          r_state <= S_RD_CAP;
        end
        S_RD_CAP: begin
          r_rd_valid <= 1'b1;
          r_rd_data  <= i_avm_rddata;
          r_remain   <= r_remain - CNT_W'(1);
          if (r_remain == CNT_W'(1)) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_avm_rd <= 1'b1;
            r_state  <= S_XFER_RD;
          end
        end
        S_DONE: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_req_ready <= 1'b0;
          r_wr_ready  <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_wr_ready   = r_wr_ready;
  assign o_rd_valid   = r_rd_valid;
  assign o_rd_data    = r_rd_data;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_avm_addr   = r_avm_addr;
  assign o_avm_wr     = r_avm_wr;
  assign o_avm_rd     = r_avm_rd;
  assign o_avm_wrdata = r_avm_wrdata;

endmodule

// File: doc/nand_cmd_sequencer.md
# nand_cmd_sequencer

Sequences one high-level NAND operation at a time onto the Avalon-MM slave register port of the NAND controller: command register write, status polling until ready, then an optional burst of data-register writes or reads. It sits between a requester (HPS bridge or test logic) and the controller's 2-bit register interface, and replaces hand-driven register traffic with a single request/response handshake.

## Interface
- DATA_W, 32, width of data register and streams
- CNT_W, 12, width of word-count field (max 4095 words per request)
- POLL_MAX, 4096, status reads before timeout error
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, request accepted when valid&ready
- req_cmd  in  8  NAND command opcode written to command register
- req_dir  in  1  0 = read words after ready, 1 = write words after ready
- req_nwords  in  CNT_W  data words to move; 0 = command only
- wr_valid / wr_ready  in / out  1 / 1  write-data stream handshake
- wr_data  in  DATA_W  write word
- rd_valid  out  1  read word valid (single-cycle pulse, no backpressure)
- rd_data  out  DATA_W  read word
- done  out  1  one-cycle pulse at end of request
- err  out  1  one-cycle pulse with done when poll timed out
- avm_addr  out  2  register select: 0 data, 1 command, 2 status
- avm_wr, avm_rd  out  1  single-cycle strobes, never both high
- avm_wrdata  out  DATA_W  write data
- avm_rddata  in  DATA_W  read data, valid exactly one cycle after avm_rd

## Operation
- States: IDLE, CMD, POLL_RD, POLL_CHK, XFER_WR, XFER_RD, RD_CAP, DONE.
- IDLE: req_ready=1. On valid&ready latch cmd, dir, nwords; -> CMD.
- CMD: avm_addr=1, avm_wr=1, avm_wrdata={zeros,req_cmd}; poll counter cleared; -> POLL_RD.
- POLL_RD: avm_addr=2, avm_rd=1; -> POLL_CHK.
- POLL_CHK: sample avm_rddata bit 0 (busy). Busy=0: nwords=0 -> DONE; dir=1 -> XFER_WR; dir=0 -> XFER_RD. Busy=1: increment poll count; count reaches POLL_MAX -> DONE with err; else -> POLL_RD.
- XFER_WR: wr_ready=1. On wr_valid: avm_addr=0, avm_wr=1, avm_wrdata=wr_data, decrement remaining; last word -> DONE. No wr_valid: stall, no bus strobe.
- XFER_RD: avm_addr=0, avm_rd=1; -> RD_CAP.
- RD_CAP: rd_valid=1, rd_data=avm_rddata; decrement remaining; zero -> DONE else -> XFER_RD.
- DONE: done=1 (err=1 if timeout); -> IDLE.
- Remaining counter is CNT_W bits, loaded with req_nwords, never wraps (tested for 1 before decrement to exit).
- Poll counter width clog2(POLL_MAX+1); saturates, no wrap.

## Timing
- Reset values: req_ready=0 while rst high, 1 in IDLE after; wr_ready, rd_valid, done, err, avm_wr, avm_rd = 0; avm_addr=0; avm_wrdata, rd_data = 0.
- All outputs are registered or pure decode of state register; no combinational path from avm_rddata to any avm_* output.
- Command-only, status not busy on first poll: accept at cycle 0, CMD cycle 1, POLL_RD 2, POLL_CHK 3, done at cycle 4; req_ready back at 5.
- Each poll iteration costs 2 cycles; each read word 2 cycles; each write word 1 cycle when wr_valid held high.
- New request accepted no earlier than the cycle after done.
- Request signals sampled only at acceptance; changes mid-operation ignored.
- rst asserted mid-operation: immediate return to IDLE, strobes drop same edge, no done pulse; partial NAND transfer is not recovered.

## Structure
- Package nand_seq_pkg: state enum, REG_DATA=2'd0, REG_CMD=2'd1, REG_STATUS=2'd2, STATUS_BUSY_BIT=0.
- Single module; no sub-module required. Poll timeout counter stays inline.

## Test plan
- Command 8'hFF, nwords=0, status returns 0 -> one avm_wr at addr 1 data 32'hFF, one avm_rd at addr 2, done at cycle 4, err=0.
- Command 8'h90, dir=0, nwords=2, status busy for 3 polls then 0, data reads return 32'h2C, 32'hDC -> 4 status reads, 2 rd_valid pulses with those values, then done.
- Command 8'h80, dir=1, nwords=3, wr_valid gapped (1,0,1,1) -> 3 avm_wr at addr 0 in order, no strobe in gap cycle, done after third.
- Status stuck busy, POLL_MAX=8 -> exactly 8 status reads, done and err pulse together, no data access.
- rst pulsed during XFER_RD of 4-word read -> strobes low next cycle, IDLE, no done; subsequent request completes normally.
- req_valid held high across done -> second request accepted only the cycle after done; avm_wr and avm_rd never high simultaneously throughout.
